fetch_wf_arbiter: RTL and testbench
===================================

// Module: fetch_wf_arbiter
// PURPOSE
// Sequences instruction fetch for the CU: holds one PC slot per wavefront and round-robin picks one eligible
// wavefront. Issues a single outstanding read to the instruction buffer port (buff_rd_en/addr/tag) and retires it on buff_ack.
// Sits between wavefront-slot allocation (dispatch), issue (done, stop_fetch), SALU (branch) and the fetch buffer.
// PARAMETERS
// NUM_WF       40  wavefront slots
// WFID_W       6   wavefront id width
// PC_W         32  byte address width
// FETCH_BYTES  32  bytes per fetch; PC advance on ack
// TAG_W        39  buff_tag width = 1 + WFID_W + PC_W
// PORTS
// clk                  in   1       clock, all state on rising edge
// rst                  in   1       reset, asynchronous, active-low (0 = reset)
// wf_launch_en         in   1       allocate slot wf_launch_wfid with start PC
// wf_launch_wfid       in   WFID_W  slot being launched
// wf_launch_pc         in   PC_W    start PC
// wf_done_en           in   1       wavefront finished; free slot
// wf_done_wfid         in   WFID_W  slot being freed
// wave_stop_fetch      in   NUM_WF  per-slot fetch inhibit (buffer full)
// salu_branch_en       in   1       branch resolved
// salu_branch_wfid     in   WFID_W  branching slot
// salu_branch_taken    in   1       1 = redirect
// salu_branch_pc_value in   PC_W    redirect target
// buff_ack             in   1       buffer accepted current request
// buff_rd_en           out  1       fetch request valid
// buff_addr            out  PC_W    fetch address
// buff_tag             out  TAG_W   {epoch, wfid, pc}
// fetch_busy           out  1       request outstanding (state REQ)
// BEHAVIOUR
// - Reset (rst=0, async): all slots invalid, pc=0, epoch=0, rr_ptr=0, state IDLE; buff_rd_en=0, buff_addr=0,
//   buff_tag=0, fetch_busy=0. Outputs drop in the same instant rst falls, even mid-request.
// - Slot state: valid, pc[PC_W], epoch (1b). eligible[i] = valid[i] & ~wave_stop_fetch[i].
// - FSM IDLE: if any eligible, pick first eligible at/after rr_ptr (wrap NUM_WF-1 -> 0); register
//   buff_addr=pc[w], buff_tag={epoch[w],w,pc[w]}, buff_rd_en=1, grant=w; go REQ. Request visible 1 cycle after pick.
// - FSM REQ: addr/tag/rd_en held stable until buff_ack. On ack: buff_rd_en=0 next edge, rr_ptr=grant+1
//   (wrap to 0 past NUM_WF-1), pc[grant]+=FETCH_BYTES (mod 2^PC_W) unless overridden below; go IDLE.
//   Minimum 2 cycles per fetch; a request is never withdrawn (stop_fetch/done/branch do not abort it).
// - Branch taken: pc[wfid]=salu_branch_pc_value, epoch[wfid] toggles; same-cycle ack on that slot does NOT
//   add FETCH_BYTES (branch wins). Not taken: no state change. Branch to invalid slot ignored.
// - Done: valid cleared; same-cycle ack on that slot leaves pc untouched. Done on invalid slot ignored.
// - Launch: valid=1, pc=wf_launch_pc, epoch toggles. Launch and done on same wfid same cycle: launch wins.
//   Launch and branch on same wfid same cycle: launch wins. Launch on an already valid slot overwrites.
// - stop_fetch sampled only in IDLE pick; a slot stopped while in REQ still completes.
// - buff_ack while IDLE ignored.
// STRUCTURE
// - fetch_pkg: NUM_WF, WFID_W, PC_W, FETCH_BYTES, TAG_W, fetch_tag_t {epoch,wfid,pc}, state enum {IDLE,REQ}.
// - Sub-module fetch_rr_picker: NUM_WF request vector + rr_ptr -> found, winner wfid (combinational).
// - Top: slot table, update priority mux (launch > done > branch > ack-advance), FSM, output regs.
// TESTING
// - Reset: launch slot 0 pc=0, pull rst low mid-REQ -> buff_rd_en=0 immediately, after release no request.
// - Single wf: launch 0 pc=0, ack each request 1 cycle later -> buff_addr 0,0x20,0x40; tag epoch=1,wfid=0.
// - Round-robin: launch slots 0,1,39 -> grant order 0,1,39,0 (wrap); stop_fetch[1]=1 -> order 0,39,0.
// - Branch race: slot 0 in REQ pc=0x20, taken branch to 0x30 same cycle as ack -> next addr 0x30, epoch toggled.
// - Done race: done slot 1 while its request pending -> request held until ack, slot 1 never requested again.
// - Launch+done same wfid same cycle: slot remains valid with new PC; next fetch at new PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch wavefront arbiter.
//   NUM_WF       wavefront slots held by the arbiter
//   WFID_W       wavefront id width
//   PC_W         byte address width
//   FETCH_BYTES  bytes fetched per request; the slot PC advances by this on ack
//   TAG_W        width of the request tag {epoch, wfid, pc}
package fetch_pkg;

  localparam int NUM_WF      = 40;
  localparam int WFID_W      = 6;
  localparam int PC_W        = 32;
  localparam int FETCH_BYTES = 32;
  localparam int TAG_W       = 1 + WFID_W + PC_W;

  // The epoch bit lets the fetch buffer discard data returned for a PC stream
  // that has since been redirected or relaunched.
  typedef struct packed {
    logic              epoch;
    logic [WFID_W-1:0] wfid;
    logic [PC_W-1:0]   pc;
  } fetch_tag_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

  // Next slot id in round-robin order, wrapping after the last slot.
  function automatic logic [WFID_W-1:0] wf_next(input logic [WFID_W-1:0] w);
    return (w == WFID_W'(NUM_WF - 1)) ? '0 : w + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_rr_picker.sv
// Combinational round-robin picker.
//   i_req   per-slot request vector
//   i_ptr   slot with highest priority this round
//   o_found at least one request is set
//   o_wfid  first requesting slot at or after i_ptr, wrapping to slot 0
module fetch_rr_picker
  import fetch_pkg::*;
(
  input  logic [NUM_WF-1:0] i_req,
  input  logic [WFID_W-1:0] i_ptr,
  output logic              o_found,
  output logic [WFID_W-1:0] o_wfid
);

  // Two descending scans, the later overriding the earlier: the first yields
  // the lowest requester overall (the wrap-around choice), the second the
  // lowest requester at or above the pointer, which wins when it exists.
  always_comb begin
    o_found = |i_req;
    o_wfid  = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (i_req[i]) o_wfid = WFID_W'(i);
    end
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (i_req[i] && (i >= int'(i_ptr))) o_wfid = WFID_W'(i);
    end
  end

endmodule

// File: rtl/fetch_wf_arbiter.sv
// Instruction fetch arbiter for one compute unit. Keeps a PC slot per
// wavefront, round-robin picks an eligible wavefront and issues a single
// outstanding read to the instruction buffer, retiring it on buff_ack.
// Ports:
//   clk, rst                     clock; asynchronous active-low reset
//   wf_launch_en/wfid/pc         allocate a slot with its start PC
//   wf_done_en/wfid              free a slot
//   wave_stop_fetch              per-slot fetch inhibit, sampled at pick time
//   salu_branch_en/wfid/taken/pc_value  branch resolution, redirects a slot
//   buff_ack                     buffer accepted the current request
//   buff_rd_en/addr/tag          fetch request (tag = {epoch, wfid, pc})
//   fetch_busy                   a request is outstanding
module fetch_wf_arbiter
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wf_launch_en,
  input  logic [WFID_W-1:0] wf_launch_wfid,
  input  logic [PC_W-1:0]   wf_launch_pc,
  input  logic              wf_done_en,
  input  logic [WFID_W-1:0] wf_done_wfid,
  input  logic [NUM_WF-1:0] wave_stop_fetch,
  input  logic              salu_branch_en,
  input  logic [WFID_W-1:0] salu_branch_wfid,
  input  logic              salu_branch_taken,
  input  logic [PC_W-1:0]   salu_branch_pc_value,
  input  logic              buff_ack,
  output logic              buff_rd_en,
  output logic [PC_W-1:0]   buff_addr,
  output logic [TAG_W-1:0]  buff_tag,
  output logic              fetch_busy
);

  fetch_state_t      r_state, w_state_nxt;
  logic [NUM_WF-1:0] r_valid;
  logic [NUM_WF-1:0] r_epoch;
  logic [PC_W-1:0]   r_pc [NUM_WF];
  logic [WFID_W-1:0] r_grant, w_grant_nxt;
  logic [WFID_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic [PC_W-1:0]   r_addr, w_addr_nxt;
  fetch_tag_t        r_tag, w_tag_nxt;

  logic [NUM_WF-1:0] w_eligible;
  logic              w_found;
  logic [WFID_W-1:0] w_pick;
  logic              w_ack;

  assign w_eligible = r_valid & ~wave_stop_fetch;
  // Acks outside REQ carry no request and are dropped.
  assign w_ack      = (r_state == REQ) && buff_ack;

  fetch_rr_picker u_picker (
    .i_req   (w_eligible),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_wfid  (w_pick)
  );

  // Slot table. Per-slot priority: launch > done > taken branch > ack advance.
  // A lower-priority event in the same cycle is simply lost, so a redirect or
  // free never sees its PC bumped by a concurrent ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_epoch <= '0;
      for (int i = 0; i < NUM_WF; i++) r_pc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_WF; i++) begin
        if (wf_launch_en && (wf_launch_wfid == WFID_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_pc[i]    <= wf_launch_pc;
          r_epoch[i] <= ~r_epoch[i];
        end else if (wf_done_en && (wf_done_wfid == WFID_W'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (salu_branch_en && salu_branch_taken && r_valid[i] &&
                     (salu_branch_wfid == WFID_W'(i))) begin
          r_pc[i]    <= salu_branch_pc_value;
          r_epoch[i] <= ~r_epoch[i];
        end else if (w_ack && (r_grant == WFID_W'(i))) begin
          r_pc[i] <= r_pc[i] + PC_W'(FETCH_BYTES);
        end
      end
    end
  end

  // Fetch FSM next state and registered request fields. Once in REQ the
  // request is frozen until acked; nothing else can withdraw it.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_en_nxt  = r_rd_en;
    w_addr_nxt   = r_addr;
    w_tag_nxt    = r_tag;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt     = REQ;
          w_rd_en_nxt     = 1'b1;
          w_addr_nxt      = r_pc[w_pick];
          w_tag_nxt.epoch = r_epoch[w_pick];
          w_tag_nxt.wfid  = w_pick;
          w_tag_nxt.pc    = r_pc[w_pick];
          w_grant_nxt     = w_pick;
        end
      end
      REQ: begin
        if (buff_ack) begin
          w_state_nxt  = IDLE;
          w_rd_en_nxt  = 1'b0;
          w_rr_ptr_nxt = wf_next(r_grant);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_rd_en  <= 1'b0;
      r_addr   <= '0;
      r_tag    <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_en  <= w_rd_en_nxt;
      r_addr   <= w_addr_nxt;
      r_tag    <= w_tag_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  assign buff_rd_en = r_rd_en;
  assign buff_addr  = r_addr;
  assign buff_tag   = r_tag;
  assign fetch_busy = (r_state == REQ);

endmodule

// File: tb/tb_fetch_wf_arbiter.sv
module tb_fetch_wf_arbiter;

  localparam int NWF = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wf_launch_en = 1'b0;
  logic [5:0]  wf_launch_wfid = '0;
  logic [31:0] wf_launch_pc = '0;
  logic        wf_done_en = 1'b0;
  logic [5:0]  wf_done_wfid = '0;
  logic [NWF-1:0] wave_stop_fetch = '0;
  logic        salu_branch_en = 1'b0;
  logic [5:0]  salu_branch_wfid = '0;
  logic        salu_branch_taken = 1'b0;
  logic [31:0] salu_branch_pc_value = '0;
  logic        buff_ack = 1'b0;
  logic        buff_rd_en;
  logic [31:0] buff_addr;
  logic [38:0] buff_tag;
  logic        fetch_busy;

  int n_total = 0;
  int n_bad   = 0;

  fetch_wf_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .wf_launch_en         (wf_launch_en),
    .wf_launch_wfid       (wf_launch_wfid),
    .wf_launch_pc         (wf_launch_pc),
    .wf_done_en           (wf_done_en),
    .wf_done_wfid         (wf_done_wfid),
    .wave_stop_fetch      (wave_stop_fetch),
    .salu_branch_en       (salu_branch_en),
    .salu_branch_wfid     (salu_branch_wfid),
    .salu_branch_taken    (salu_branch_taken),
    .salu_branch_pc_value (salu_branch_pc_value),
    .buff_ack             (buff_ack),
    .buff_rd_en           (buff_rd_en),
    .buff_addr            (buff_addr),
    .buff_tag             (buff_tag),
    .fetch_busy           (fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wf_launch_en = 1'b0; wf_done_en = 1'b0; salu_branch_en = 1'b0;
    salu_branch_taken = 1'b0; buff_ack = 1'b0; wave_stop_fetch = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic launch(input logic [5:0] w, input logic [31:0] pc);
    wf_launch_en = 1'b1; wf_launch_wfid = w; wf_launch_pc = pc;
    tick();
    wf_launch_en = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!buff_rd_en && n < 50) begin
      tick();
      n++;
    end
    if (!buff_rd_en) check("req_timeout", 64'd0, 64'd1);
  endtask

  // Wait for a request, capture it, and ack it for one cycle.
  task automatic fetch_one(output logic [5:0] wf, output logic [31:0] addr, output logic ep);
    wait_req();
    wf   = buff_tag[37:32];
    addr = buff_addr;
    ep   = buff_tag[38];
    buff_ack = 1'b1;
    tick();
    buff_ack = 1'b0;
  endtask

  logic [5:0]  wf;
  logic [31:0] addr;
  logic        ep;

  initial begin
    // Reset values
    do_reset();
    check("rst_rd_en", 64'(buff_rd_en), 64'd0);
    check("rst_addr",  64'(buff_addr),  64'd0);
    check("rst_tag",   64'(buff_tag),   64'd0);
    check("rst_busy",  64'(fetch_busy), 64'd0);

    // Ack while idle has no effect
    buff_ack = 1'b1; tick(); buff_ack = 1'b0;
    check("idle_ack_rd_en", 64'(buff_rd_en), 64'd0);

    // Async reset drops a pending request immediately
    launch(6'd0, 32'h0);
    wait_req();
    check("pre_rst_rd_en", 64'(buff_rd_en), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_rd_en", 64'(buff_rd_en), 64'd0);
    check("async_rst_busy",  64'(fetch_busy), 64'd0);
    #2 rst = 1'b1;
    repeat (3) tick();
    check("post_rst_no_req", 64'(buff_rd_en), 64'd0);

    // Single wavefront: addresses 0, 0x20, 0x40; launch makes epoch 1
    do_reset();
    launch(6'd0, 32'h0);
    wait_req();
    check("single_tag0", 64'(buff_tag), {25'd0, 1'b1, 6'd0, 32'h0});
    check("single_busy", 64'(fetch_busy), 64'd1);
    repeat (2) tick();
    check("hold_rd_en", 64'(buff_rd_en), 64'd1);
    check("hold_addr",  64'(buff_addr),  64'h0);
    fetch_one(wf, addr, ep);
    check("single_addr0", 64'(addr), 64'h0);
    check("ack_drops_rd_en", 64'(buff_rd_en), 64'd0);
    fetch_one(wf, addr, ep);
    check("single_addr1", 64'(addr), 64'h20);
    fetch_one(wf, addr, ep);
    check("single_addr2", 64'(addr), 64'h40);
    check("single_ep",    64'(ep),   64'd1);
    check("single_wf",    64'(wf),   64'd0);

    // Round robin over slots 0,1,39 with wrap
    do_reset();
    wave_stop_fetch = '1;
    launch(6'd0, 32'h1000);
    launch(6'd1, 32'h2000);
    launch(6'd39, 32'h3000);
    wave_stop_fetch = '0;
    fetch_one(wf, addr, ep); check("rr_g0", 64'(wf), 64'd0);
    check("rr_a0", 64'(addr), 64'h1000);
    fetch_one(wf, addr, ep); check("rr_g1", 64'(wf), 64'd1);
    fetch_one(wf, addr, ep); check("rr_g2", 64'(wf), 64'd39);
    check("rr_a2", 64'(addr), 64'h3000);
    fetch_one(wf, addr, ep); check("rr_g3", 64'(wf), 64'd0);
    check("rr_a3", 64'(addr), 64'h1020);

    // Round robin with slot 1 stopped
    do_reset();
    wave_stop_fetch = '1;
    launch(6'd0, 32'h1000);
    launch(6'd1, 32'h2000);
    launch(6'd39, 32'h3000);
    wave_stop_fetch = '0;
    wave_stop_fetch[1] = 1'b1;
    fetch_one(wf, addr, ep); check("stop_g0", 64'(wf), 64'd0);
    fetch_one(wf, addr, ep); check("stop_g1", 64'(wf), 64'd39);
    fetch_one(wf, addr, ep); check("stop_g2", 64'(wf), 64'd0);
    wave_stop_fetch = '0;

    // Taken branch in the same cycle as the ack: branch wins, epoch toggles
    do_reset();
    launch(6'd0, 32'h0);
    fetch_one(wf, addr, ep);
    wait_req();
    check("br_pre_addr", 64'(buff_addr), 64'h20);
    salu_branch_en = 1'b1; salu_branch_taken = 1'b1;
    salu_branch_wfid = 6'd0; salu_branch_pc_value = 32'h30;
    buff_ack = 1'b1;
    tick();
    salu_branch_en = 1'b0; salu_branch_taken = 1'b0; buff_ack = 1'b0;
    fetch_one(wf, addr, ep);
    check("br_addr", 64'(addr), 64'h30);
    check("br_ep",   64'(ep),   64'd0);
    fetch_one(wf, addr, ep);
    check("br_addr_next", 64'(addr), 64'h50);

    // Not-taken branch changes nothing
    salu_branch_en = 1'b1; salu_branch_taken = 1'b0;
    salu_branch_wfid = 6'd0; salu_branch_pc_value = 32'h900;
    tick();
    salu_branch_en = 1'b0;
    fetch_one(wf, addr, ep);
    check("nt_addr", 64'(addr), 64'h70);

    // Done on slot 1 while its request is pending
    do_reset();
    wave_stop_fetch = '1;
    launch(6'd0, 32'h100);
    launch(6'd1, 32'h200);
    wave_stop_fetch = '0;
    fetch_one(wf, addr, ep); check("done_g0", 64'(wf), 64'd0);
    wait_req();
    check("done_pend_wf", 64'(buff_tag[37:32]), 64'd1);
    wf_done_en = 1'b1; wf_done_wfid = 6'd1;
    tick();
    wf_done_en = 1'b0;
    tick();
    check("done_hold_rd_en", 64'(buff_rd_en), 64'd1);
    check("done_hold_addr",  64'(buff_addr),  64'h200);
    buff_ack = 1'b1; tick(); buff_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fetch_one(wf, addr, ep);
      check("done_only_wf0", 64'(wf), 64'd0);
    end

    // Launch and done on the same slot in the same cycle: launch wins
    do_reset();
    wave_stop_fetch = '1;
    launch(6'd2, 32'h100);
    wf_launch_en = 1'b1; wf_launch_wfid = 6'd2; wf_launch_pc = 32'h200;
    wf_done_en = 1'b1; wf_done_wfid = 6'd2;
    tick();
    wf_launch_en = 1'b0; wf_done_en = 1'b0;
    wave_stop_fetch = '0;
    fetch_one(wf, addr, ep);
    check("ld_wf",   64'(wf),   64'd2);
    check("ld_addr", 64'(addr), 64'h200);
    check("ld_ep",   64'(ep),   64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
